// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access
// sizes, fault cause codes and small decode helpers.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StResp = 2'd3
    } lsu_state_e;

    // funct3[1:0] encodes the access width for both loads and stores.
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    localparam logic [1:0] CauseNone     = 2'd0;
    localparam logic [1:0] CauseMisalign = 2'd1;
    localparam logic [1:0] CauseRange    = 2'd2;
    localparam logic [1:0] CauseIllegal  = 2'd3;

    // Loads allow LB/LH/LW/LBU/LHU; stores allow SB/SH/SW only.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 > 3'b010;
        end
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane alignment helper for the load/store unit (purely combinational).
//   funct3_i     : latched funct3 of the request
//   lane_i       : byte lane, addr[1:0]
//   rdata_i      : word read from the data cache
//   wdata_i      : low half of the store data (SB uses [7:0], SH uses [15:0])
//   load_data_o  : selected byte/half/word, sign- or zero-extended
//   merge_data_o : rdata_i with the addressed store lane(s) replaced
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{lane_i, 3'b000} +: 8];
        half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // funct3[2] selects zero extension (LBU/LHU).
        case (funct3_i[1:0])
            SizeByte: load_data_o = {{24{byte_v[7] & ~funct3_i[2]}}, byte_v};
            SizeHalf: load_data_o = {{16{half_v[15] & ~funct3_i[2]}}, half_v};
            default:  load_data_o = rdata_i;
        endcase

        merge_data_o = rdata_i;
        case (funct3_i[1:0])
            SizeByte: merge_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            SizeHalf: merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
            default:  merge_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store per handshake, checks it,
// drives the data cache (word-aligned read, write, or read-modify-write for
// SB/SH) and returns extended load data or a store acknowledgement.
//
// Optional feature macro LSU_MISALIGN_TRAP_EN:
//   defined   - misaligned half/word accesses fault with cause 1
//   undefined - the address is forced to natural alignment instead
//
// Ports:
//   i_clk, i_rst           clock (rising edge), async active-low reset
//   i_req_*, o_req_ready   request from execute (ready only in idle)
//   o_resp_*, i_resp_ready response to writeback, held until accepted
//   o_fault, o_fault_cause fault flag and cause (1 misalign, 2 range, 3 funct3)
//   o_dc_*, i_dc_val       data cache interface (combinational read data)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter logic [31:0] CACHE_OFFSET = 32'h0000_1000,
    parameter logic [31:0] CACHE_SIZE   = 32'h0000_03ff
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_rd,
    output logic        o_resp_we,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic [31:0] o_dc_address,
    output logic [31:0] o_dc_val,
    output logic        o_dc_op_type,
    input  logic [31:0] i_dc_val
);

    lsu_state_e state_q, state_d;

    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_we_q, resp_we_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] dc_addr_q, dc_addr_d;
    logic [31:0] dc_val_q, dc_val_d;
    logic        dc_op_q, dc_op_d;

    // Request checks, evaluated on the raw inputs at accept.
    logic [1:0]  req_size;
    logic [2:0]  req_bytes;
    logic [31:0] acc_addr;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_out_range;
    logic        req_fault;
    logic [1:0]  req_cause;
    logic [32:0] acc_lo, acc_hi, win_lo, win_hi;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    load_store_unit_align u_align (
        .funct3_i     (funct3_q),
        .lane_i       (lane_q),
        .rdata_i      (i_dc_val),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_comb begin
        req_size    = i_funct3[1:0];
        req_bytes   = access_bytes(req_size);
        req_illegal = funct3_illegal(i_req_we, i_funct3);
        acc_addr    = i_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((req_size == SizeHalf) && i_addr[0])
                      || ((req_size == SizeWord) && (i_addr[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
        if (req_size == SizeHalf) begin
            acc_addr[0] = 1'b0;
        end else if (req_size == SizeWord) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
        // 33-bit compare so an access near 0xFFFF_FFFF cannot wrap into range.
        acc_lo        = {1'b0, acc_addr};
        acc_hi        = acc_lo + {30'd0, req_bytes} - 33'd1;
        win_lo        = {1'b0, CACHE_OFFSET};
        win_hi        = win_lo + {1'b0, CACHE_SIZE};
        req_out_range = (acc_lo < win_lo) || (acc_hi > win_hi);

        req_fault = 1'b1;
        if (req_illegal) begin
            req_cause = CauseIllegal;
        end else if (req_misaligned) begin
            req_cause = CauseMisalign;
        end else if (req_out_range) begin
            req_cause = CauseRange;
        end else begin
            req_cause = CauseNone;
            req_fault = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_we_d    = resp_we_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        dc_addr_d    = dc_addr_q;
        dc_val_d     = dc_val_q;
        dc_op_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    we_d      = i_req_we;
                    funct3_d  = i_funct3;
                    lane_d    = acc_addr[1:0];
                    wdata_d   = i_wdata[15:0];
                    resp_rd_d = i_rd;
                    fault_d   = req_fault;
                    cause_d   = req_cause;
                    if (req_fault) begin
                        // Straight to response; the cache is not touched.
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_data_d  = 32'd0;
                        resp_we_d    = 1'b0;
                    end else begin
                        dc_addr_d = {acc_addr[31:2], 2'b00};
                        if (i_req_we && (req_size == SizeWord)) begin
                            state_d  = StWr;
                            dc_op_d  = 1'b1;
                            dc_val_d = i_wdata;
                        end else begin
                            // Loads and sub-word stores both need the old word.
                            state_d = StRd;
                        end
                    end
                end
            end
            StRd: begin
                if (we_q) begin
                    state_d  = StWr;
                    dc_op_d  = 1'b1;
                    dc_val_d = merge_data;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_data;
                    resp_we_d    = 1'b1;
                end
            end
            StWr: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_data_d  = 32'd0;
                resp_we_d    = 1'b0;
            end
            StResp: begin
                if (i_resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            resp_we_q    <= 1'b0;
            fault_q      <= 1'b0;
            cause_q      <= CauseNone;
            dc_addr_q    <= CACHE_OFFSET;
            dc_val_q     <= 32'd0;
            dc_op_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_we_q    <= resp_we_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            dc_addr_q    <= dc_addr_d;
            dc_val_q     <= dc_val_d;
            dc_op_q      <= dc_op_d;
        end
    end

    assign o_req_ready   = (state_q == StIdle);
    assign o_resp_valid  = resp_valid_q;
    assign o_resp_data   = resp_data_q;
    assign o_resp_rd     = resp_rd_q;
    assign o_resp_we     = resp_we_q;
    assign o_fault       = fault_q;
    assign o_fault_cause = cause_q;
    assign o_dc_address  = dc_addr_q;
    assign o_dc_val      = dc_val_q;
    assign o_dc_op_type  = dc_op_q;

endmodule
